mem_access: RTL

Memory-access stage directly downstream of the execute stage: consumes the execute stage's `execute_data_t` bundle, performs loads/stores over the data bus with a held-request handshake, and produces the `memory_data_t` bundle for writeback. It aligns store data and strobes, and extracts and extends load data. It stalls the pipeline while an access is outstanding. A result buffer prevents a completed access from being re-issued while the pipeline is frozen for another reason.

---
 rtl/mem_access_if.sv | 49 ++++
 rtl/mem_access.sv | 58 +++++
 2 files changed

// File: rtl/mem_access_if.sv
// mem_access_if: pipeline/data-bus bundle types and the interface carrying them.
package mem_access_pkg;
  typedef struct packed {
    logic regWrite;
    logic memRead;
    logic memWrite;
    logic memUnsigned;
    logic misaligned;
    logic [3:0] msize;
  } ctl_t;
  typedef struct packed {
    logic [63:0] pc;
    logic valid;
    ctl_t ctl;
    logic [63:0] alu_out;
    logic [63:0] srcb;
    logic [4:0] dst;
  } execute_data_t;
  typedef struct packed {
    logic [63:0] pc;
    logic valid;
    ctl_t ctl;
    logic [4:0] dst;
    logic [63:0] result;
  } memory_data_t;
  typedef struct packed {
    logic valid;
    logic [63:0] addr;
    logic [3:0] size;
    logic [7:0] strobe;
    logic [63:0] data;
  } dbus_req_t;
  typedef struct packed {
    logic data_ok;
    logic [63:0] data;
  } dbus_resp_t;
endpackage

interface mem_access_if;
  import mem_access_pkg::*;
  execute_data_t dataE;
  logic stall_other;
  dbus_resp_t dresp;
  dbus_req_t dreq;
  memory_data_t dataM;
  logic stallM;
  modport master(input dataE, stall_other, dresp, output dreq, dataM, stallM);
  modport slave(output dataE, stall_other, dresp, input dreq, dataM, stallM);
endinterface

// File: rtl/mem_access.sv
// mem_access: load/store stage with held bus request and frozen-result buffer.
// Define MEM_ALIGN_CHECK_EN to suppress misaligned accesses and flag them in ctl.misaligned.
module mem_access
  import mem_access_pkg::*;
(
  input logic clk,
  input logic reset,
  mem_access_if.master m
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state;
  logic [63:0] rbuf, raw, ext;
  logic [7:0] mask;
  logic [2:0] off;
  logic mis, mem_op, req, done, sx;
  always_comb begin
    off = m.dataE.alu_out[2:0];
    mask = m.dataE.ctl.msize == 4'd8 ? 8'hff : m.dataE.ctl.msize == 4'd4 ? 8'h0f :
           m.dataE.ctl.msize == 4'd2 ? 8'h03 : 8'h01;
`ifdef MEM_ALIGN_CHECK_EN
    mis = m.dataE.valid & (m.dataE.ctl.memRead | m.dataE.ctl.memWrite) &
          (|(off & (m.dataE.ctl.msize[2:0] - 3'd1)));
`else
    mis = 1'b0;
`endif
    mem_op = m.dataE.valid & (m.dataE.ctl.memRead | m.dataE.ctl.memWrite) & ~mis;
    // WAIT keeps the request up on its own so it cannot drop before data_ok
    req = state == WAIT | (state == IDLE & mem_op);
    done = req & m.dresp.data_ok;
    sx = ~m.dataE.ctl.memUnsigned;
    raw = m.dresp.data >> {off, 3'b000};
    ext = m.dataE.ctl.msize == 4'd8 ? raw :
          m.dataE.ctl.msize == 4'd4 ? {{32{sx & raw[31]}}, raw[31:0]} :
          m.dataE.ctl.msize == 4'd2 ? {{48{sx & raw[15]}}, raw[15:0]} :
                                      {{56{sx & raw[7]}}, raw[7:0]};
    m.dreq.valid = req;
    m.dreq.addr = m.dataE.alu_out;
    m.dreq.size = m.dataE.ctl.msize;
    m.dreq.strobe = m.dataE.ctl.memWrite ? mask << off : 8'h00;
    m.dreq.data = m.dataE.srcb << {off, 3'b000};
    m.dataM.pc = m.dataE.pc;
    m.dataM.valid = m.dataE.valid;
    m.dataM.ctl = m.dataE.ctl;
    m.dataM.ctl.misaligned = mis;
    m.dataM.dst = m.dataE.dst;
    m.dataM.result = state == DONE ? rbuf : mem_op ? ext : m.dataE.alu_out;
    m.stallM = req & ~m.dresp.data_ok;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rbuf <= '0;
    end else begin
      if (done) rbuf <= ext;
      state <= (done | state == DONE) ? (m.stall_other ? DONE : IDLE) : req ? WAIT : IDLE;
    end
  end
endmodule
